// File: rtl/nand_equiv_sweeper.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// nand_equiv_sweeper
//
// Sequential equivalence sweeper for NAND-only logic. It walks every operand
// pair (a, b) of WIDTH bits each and applies both to two paths:
//   * a structural network built only from 2-input NAND cells, per bit
//   * a plain behavioural expression for the same function
// The two results go through a one-deep compare stage. The block counts the
// mismatches, records the first failing vector and raises a pass flag.
//
// Parameters:
//   WIDTH            operand width in bits (1..8)
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            sweep request, sampled only in IDLE
//   op[2:0]          0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a,
//                    7 illegal (rejected with err)
//   abort            synchronous cancel of a running sweep
//   busy             high while vectors are being issued (RUN)
//   done             one-cycle pulse at sweep completion
//   pass             1 when the completed sweep saw no mismatches
//   err              one-cycle pulse when start is sampled with op==7
//   mismatch_cnt     mismatches in the current or last sweep
//   first_fail_valid a mismatch has been captured in this sweep
//   first_fail_a/b   operands of the first mismatch
//
// Optional feature (macro NAND_FAULT_INJ_EN):
//   fault_en         when latched high, invert one structural result bit
//   fault_sel[2:0]   index of the bit to invert; >= WIDTH inverts nothing
//   Both are latched when a start is accepted. With the macro undefined
//   these ports do not exist and the structural path is untouched.
// ----------------------------------------------------------------------------
module nand_equiv_sweeper #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               abort,
`ifdef NAND_FAULT_INJ_EN
    input  logic               fault_en,
    input  logic [2:0]         fault_sel,
`endif
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               err,
    output logic [2*WIDTH:0]   mismatch_cnt,
    output logic               first_fail_valid,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int             CW         = 2 * WIDTH + 1;
    localparam int             N          = 1 << (2 * WIDTH);
    localparam logic [CW-1:0]  LAST_IDX   = CW'(N - 1);
    localparam logic [2:0]     OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    idx_q;
    logic [2:0]       op_q;

    logic             stg_valid_q;
    logic [WIDTH-1:0] stg_a_q;
    logic [WIDTH-1:0] stg_b_q;
    logic [WIDTH-1:0] stg_struct_q;
    logic [WIDTH-1:0] stg_ref_q;

    logic             accept;
    logic             reject;
    logic             issue;
    logic             finish;

    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;

    logic [WIDTH-1:0] s_and, s_or, s_nand, s_nor, s_xor, s_xnor, s_nota;
    logic [WIDTH-1:0] struct_sel;
    logic [WIDTH-1:0] struct_res;
    logic [WIDTH-1:0] ref_res;

`ifdef NAND_FAULT_INJ_EN
    logic             fault_en_q;
    logic [2:0]       fault_sel_q;
    logic [WIDTH-1:0] fault_mask;
`endif

    // The single primitive the structural network is allowed to use.
    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // The vector index is split so a is the high half and b the low half;
    // walking idx upward therefore enumerates every (a, b) pair once.
    assign cur_a = idx_q[2*WIDTH-1:WIDTH];
    assign cur_b = idx_q[WIDTH-1:0];

    // Per-bit NAND-only network. Every function is derived from the same
    // handful of NAND cells, so a wiring mistake in a shared cell shows up
    // across several ops at once.
    for (genvar i = 0; i < WIDTH; i++) begin : g_nand_net
        logic n_ab, n_a, n_b, n_xa, n_xb;

        assign n_ab      = nand2(cur_a[i], cur_b[i]);
        assign n_a       = nand2(cur_a[i], cur_a[i]);
        assign n_b       = nand2(cur_b[i], cur_b[i]);
        assign n_xa      = nand2(cur_a[i], n_ab);
        assign n_xb      = nand2(cur_b[i], n_ab);

        assign s_nand[i] = n_ab;
        assign s_and[i]  = nand2(n_ab, n_ab);
        assign s_nota[i] = n_a;
        assign s_or[i]   = nand2(n_a, n_b);
        assign s_nor[i]  = nand2(s_or[i], s_or[i]);
        assign s_xor[i]  = nand2(n_xa, n_xb);
        assign s_xnor[i] = nand2(s_xor[i], s_xor[i]);
    end

    // Pick the structural output that corresponds to the latched function.
    // The illegal code never reaches RUN, so its arm is only a default.
    always_comb begin
        struct_sel = '0;
        case (op_q)
            3'd0:    struct_sel = s_and;
            3'd1:    struct_sel = s_or;
            3'd2:    struct_sel = s_nand;
            3'd3:    struct_sel = s_nor;
            3'd4:    struct_sel = s_xor;
            3'd5:    struct_sel = s_xnor;
            3'd6:    struct_sel = s_nota;
            default: struct_sel = '0;
        endcase
    end

`ifdef NAND_FAULT_INJ_EN
    // Build a one-hot flip mask from the latched fault selection. A select
    // beyond the operand width matches no bit, so nothing is inverted.
    always_comb begin
        fault_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (fault_en_q && (fault_sel_q == 3'(i))) begin
                fault_mask[i] = 1'b1;
            end
        end
    end

    assign struct_res = struct_sel ^ fault_mask;
`else
    assign struct_res = struct_sel;
`endif

    // Behavioural reference: the function written as a plain expression.
    always_comb begin
        ref_res = '0;
        case (op_q)
            3'd0:    ref_res = cur_a & cur_b;
            3'd1:    ref_res = cur_a | cur_b;
            3'd2:    ref_res = ~(cur_a & cur_b);
            3'd3:    ref_res = ~(cur_a | cur_b);
            3'd4:    ref_res = cur_a ^ cur_b;
            3'd5:    ref_res = ~(cur_a ^ cur_b);
            3'd6:    ref_res = ~cur_a;
            default: ref_res = '0;
        endcase
    end

    // State register for the sweep controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the strobes the datapath acts on. Abort only
    // matters while a sweep is in flight; in IDLE a start always wins.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (op != OP_ILLEGAL)) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else if (start) begin
                    reject  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    issue = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);

    // Datapath: operand latch, vector index, compare stage and result
    // registers. The compare stage is cleared whenever nothing is issued,
    // which also drops the in-flight vector on the abort edge's successor.
    // The index parks at the last vector instead of wrapping around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q            <= '0;
            op_q             <= '0;
            stg_valid_q      <= 1'b0;
            stg_a_q          <= '0;
            stg_b_q          <= '0;
            stg_struct_q     <= '0;
            stg_ref_q        <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_a     <= '0;
            first_fail_b     <= '0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err              <= 1'b0;
`ifdef NAND_FAULT_INJ_EN
            fault_en_q       <= 1'b0;
            fault_sel_q      <= '0;
`endif
        end else begin
            err  <= reject;
            done <= finish;

            if (stg_valid_q && (stg_struct_q != stg_ref_q)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_a     <= stg_a_q;
                    first_fail_b     <= stg_b_q;
                end
            end

            if (issue) begin
                stg_valid_q  <= 1'b1;
                stg_a_q      <= cur_a;
                stg_b_q      <= cur_b;
                stg_struct_q <= struct_res;
                stg_ref_q    <= ref_res;
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                stg_valid_q  <= 1'b0;
            end

            if (accept) begin
                op_q             <= op;
                idx_q            <= '0;
                mismatch_cnt     <= '0;
                first_fail_valid <= 1'b0;
                first_fail_a     <= '0;
                first_fail_b     <= '0;
                pass             <= 1'b0;
`ifdef NAND_FAULT_INJ_EN
                fault_en_q       <= fault_en;
                fault_sel_q      <= fault_sel;
`endif
            end

            if (finish) begin
                pass <= (mismatch_cnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_nand_equiv_sweeper.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_nand_equiv_sweeper
//
// Bench for nand_equiv_sweeper at WIDTH=2 (16 vectors per sweep). Expected
// results come from a reference model that enumerates every operand pair
// with plain integer arithmetic. Build with NAND_FAULT_INJ_EN defined to
// also drive the fault-injection ports.
// ----------------------------------------------------------------------------
module tb_nand_equiv_sweeper;

    localparam int W    = 2;
    localparam int N    = 1 << (2 * W);
    localparam int MASK = (1 << W) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic             abort;
    logic             fault_en;
    logic [2:0]       fault_sel;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err;
    logic [2*W:0]     mismatch_cnt;
    logic             first_fail_valid;
    logic [W-1:0]     first_fail_a;
    logic [W-1:0]     first_fail_b;

    int total;
    int bad;
    int lastCnt;
    int lastPass;

    nand_equiv_sweeper #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .op               (op),
        .abort            (abort),
`ifdef NAND_FAULT_INJ_EN
        .fault_en         (fault_en),
        .fault_sel        (fault_sel),
`endif
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err              (err),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_a     (first_fail_a),
        .first_fail_b     (first_fail_b)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive every input in one place; fault ports only matter when built in.
    task automatic applyStimulus(input logic st, input int o, input logic ab,
                                 input logic fen, input int fsel);
        start     = st;
        op        = 3'(o);
        abort     = ab;
        fault_en  = fen;
        fault_sel = 3'(fsel);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Function value for one operand pair, straight from the op table.
    function automatic int refOp(input int o, input int a, input int b);
        case (o)
            0:       return a & b;
            1:       return a | b;
            2:       return ~(a & b) & MASK;
            3:       return ~(a | b) & MASK;
            4:       return a ^ b;
            5:       return ~(a ^ b) & MASK;
            6:       return ~a & MASK;
            default: return 0;
        endcase
    endfunction

    // Whole-sweep reference: a correct NAND network equals the function, so
    // the structural value differs only by the injected fault bit.
    task automatic modelSweep(input int o, input int fen, input int fsel,
                              output int cnt, output int ffv,
                              output int ffa, output int ffb);
        int flip;
        flip = (fen != 0 && fsel < W) ? (1 << fsel) : 0;
        cnt = 0; ffv = 0; ffa = 0; ffb = 0;
        for (int v = 0; v < N; v++) begin
            int a, b, r, s;
            a = v >> W;
            b = v & MASK;
            r = refOp(o, a, b);
            s = r ^ flip;
            if (s != r) begin
                if (ffv == 0) begin
                    ffv = 1; ffa = a; ffb = b;
                end
                cnt++;
            end
        end
    endtask

    // Full sweep with timing and result checks. midStart >= 0 pulses a
    // (to-be-ignored) start during that cycle of the sweep.
    task automatic runSweep(input string tag, input int o, input int fen,
                            input int fsel, input int midStart);
        int eCnt, eFfv, eFfa, eFfb;
        int busyCnt, doneCnt, doneAt, errCnt;
        modelSweep(o, fen, fsel, eCnt, eFfv, eFfa, eFfb);
        applyStimulus(1'b1, o, 1'b0, fen[0], fsel);
        tick();
        // Scramble the inputs after acceptance; the DUT must use latched copies.
        applyStimulus(1'b0, int'($urandom_range(0, 6)), 1'b0, 1'($urandom), int'($urandom_range(0, 7)));
        busyCnt = 0; doneCnt = 0; doneAt = -1; errCnt = 0;
        for (int k = 0; k < N + 6; k++) begin
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) begin doneCnt++; doneAt = k; end
            if (err === 1'b1) errCnt++;
            start = (k == midStart);
            if (k == midStart) op = 3'($urandom_range(0, 7));
            tick();
        end
        start = 1'b0;
        checkOutput({tag, ".busy_cycles"}, busyCnt, N);
        checkOutput({tag, ".done_count"}, doneCnt, 1);
        checkOutput({tag, ".done_at"}, doneAt, N + 2);
        checkOutput({tag, ".err_count"}, errCnt, 0);
        checkOutput({tag, ".pass"}, pass, (eCnt == 0) ? 1 : 0);
        checkOutput({tag, ".mismatch_cnt"}, mismatch_cnt, eCnt);
        checkOutput({tag, ".ff_valid"}, first_fail_valid, eFfv);
        checkOutput({tag, ".ff_a"}, first_fail_a, eFfa);
        checkOutput({tag, ".ff_b"}, first_fail_b, eFfb);
        lastCnt  = eCnt;
        lastPass = (eCnt == 0) ? 1 : 0;
    endtask

    // Count done/busy over a window where neither should appear.
    task automatic expectQuiet(input string tag, input int cycles);
        int doneCnt, busyCnt;
        doneCnt = 0; busyCnt = 0;
        for (int k = 0; k < cycles; k++) begin
            if (done === 1'b1) doneCnt++;
            if (busy === 1'b1) busyCnt++;
            tick();
        end
        checkOutput({tag, ".no_done"}, doneCnt, 0);
        checkOutput({tag, ".no_busy"}, busyCnt, 0);
    endtask

    // Start a sweep, raise abort in RUN cycle abortAt (0-based; N = FLUSH).
    task automatic abortSweep(input string tag, input int o, input int abortAt);
        applyStimulus(1'b1, o, 1'b0, 1'b0, 0);
        tick();
        start = 1'b0;
        for (int k = 0; k < abortAt; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput({tag, ".busy_after_abort"}, busy, 0);
        checkOutput({tag, ".pass_after_abort"}, pass, 0);
        expectQuiet(tag, N + 4);
        checkOutput({tag, ".partial_cnt"}, mismatch_cnt, 0);
    endtask

    initial begin
        int o;
        total = 0; bad = 0; lastCnt = 0; lastPass = 0;
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;

        // Reset held with start high: everything stays cleared.
        repeat (3) tick();
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.pass", pass, 0);
        checkOutput("rst.err", err, 0);
        checkOutput("rst.mismatch_cnt", mismatch_cnt, 0);
        checkOutput("rst.ff_valid", first_fail_valid, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("rst.idle_after_release", busy, 0);

        // Every legal function on a healthy network.
        for (int i = 0; i <= 6; i++) begin
            $display("[TB] sweep op=%0d", i);
            runSweep($sformatf("op%0d", i), i, 0, 0, -1);
        end

        // Illegal op: error pulse, no sweep, previous results untouched.
        applyStimulus(1'b1, 7, 1'b0, 1'b0, 0);
        tick();
        start = 1'b0;
        checkOutput("op7.err_pulse", err, 1);
        checkOutput("op7.busy", busy, 0);
        tick();
        checkOutput("op7.err_one_cycle", err, 0);
        expectQuiet("op7", N + 4);
        checkOutput("op7.mismatch_kept", mismatch_cnt, lastCnt);
        checkOutput("op7.pass_kept", pass, lastPass);

`ifdef NAND_FAULT_INJ_EN
        // Fault on bit 0 breaks every vector; out-of-range select is inert.
        runSweep("fault_sel0", 0, 1, 0, -1);
        runSweep("fault_sel5", 0, 1, 5, -1);
`endif

        // Abort on the 5th RUN cycle, then a clean XNOR sweep.
        abortSweep("abort5", 4, 4);
        runSweep("after_abort", 5, 0, 0, -1);

        // Abort at a random point, including the flush cycle.
        abortSweep("abort_rand", int'($urandom_range(0, 6)), int'($urandom_range(1, N)));

        // Start while busy is ignored; schedule unchanged.
        runSweep("start_while_busy", 1, 0, 0, 3);

        // Random sweeps with random gaps and stray starts.
        for (int r = 0; r < 6; r++) begin
            int fen, fsel, ms;
            o    = int'($urandom_range(0, 6));
            fen  = 0;
            fsel = 0;
`ifdef NAND_FAULT_INJ_EN
            fen  = int'($urandom_range(0, 1));
            fsel = int'($urandom_range(0, 7));
`endif
            ms   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 1)) : -1;
            repeat ($urandom_range(0, 3)) tick();
            runSweep($sformatf("rand%0d", r), o, fen, fsel, ms);
        end

        // Make sure pass is set, then reset in the 8th RUN cycle.
        runSweep("pre_reset", 2, 0, 0, -1);
        applyStimulus(1'b1, 3, 1'b0, 1'b0, 0);
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.busy", busy, 0);
        checkOutput("midrst.done", done, 0);
        checkOutput("midrst.pass", pass, 0);
        checkOutput("midrst.err", err, 0);
        checkOutput("midrst.mismatch_cnt", mismatch_cnt, 0);
        checkOutput("midrst.ff_valid", first_fail_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expectQuiet("midrst", N + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nand_equiv_sweeper.md
Name: nand_equiv_sweeper

Overview:
- Self-checking sequential equivalence sweeper for NAND-only logic implementations.
- Generalises the two-input "gate network vs. original expression" comparison to WIDTH-bit bitwise operands and a selectable function.
- Steps through all 2^(2*WIDTH) operand pairs and compares the NAND-only structural network against a behavioural expression for the same function.
- Reports the mismatch count, the first failing vector and a pass flag; used as an on-chip/bench checker for the logic-unit work.

Parameters:
- WIDTH, 4, operand width in bits; legal 1..8.
- N (localparam), 2**(2*WIDTH), number of vectors per sweep.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a sweep; sampled only in IDLE
- op  input  3  function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 illegal
- abort  input  1  synchronous cancel of a running sweep
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at sweep completion
- pass  output  1  valid from done onward: 1 when mismatch_cnt==0
- err  output  1  one-cycle pulse when start is sampled with op==7
- mismatch_cnt  output  2*WIDTH+1  mismatches in current/last sweep
- first_fail_valid  output  1  a mismatch has been captured this sweep
- first_fail_a  output  WIDTH  a operand of first mismatch
- first_fail_b  output  WIDTH  b operand of first mismatch

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs, vector index, stage register and latched op cleared to 0.
- Structural path: built only from 2-input NAND primitives, bitwise per bit; reference path is a plain expression. Both are combinational from the stage-0 vector.
- FSM states IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start && op!=7 -> latch op, clear mismatch_cnt, first_fail_*, pass, idx=0, go RUN.
  - start && op==7 -> err=1 for one cycle, stay IDLE.
- RUN:
  - Each cycle: a=idx[2W-1:W], b=idx[W-1:0]. Register {a, b, struct_result, ref_result} into the compare stage (valid=1). idx++.
  - After issuing idx==N-1, go FLUSH.
- Compare stage: when valid and results differ, mismatch_cnt++. If first_fail_valid==0, capture a and b and set first_fail_valid.
- FLUSH: the last vector retires; go DONE.
- DONE: done=1 and pass=(mismatch_cnt==0) for one cycle; go IDLE. pass, mismatch_cnt and first_fail_* hold until the next accepted start.
- Latency: start accepted at edge E0; done high in the cycle after edge E(N+2). busy is high for exactly N cycles.
- start while not IDLE: ignored, no err.
- abort in RUN/FLUSH: next edge -> IDLE, valid cleared, done and pass not asserted. mismatch_cnt and first_fail_* keep their partial values. abort in IDLE/DONE: no effect.
- abort and start both high in IDLE: start wins (abort is a don't-care there).
- Counter: idx is 2*WIDTH+1 bits and stops at N-1 (no wrap into a second pass). mismatch_cnt maximum is N, so it cannot overflow.
- rst_n asserted mid-sweep: immediate return to reset values; no done.

Optional Feature:
- Macro NAND_FAULT_INJ_EN.
- Defined:
  - Adds inputs fault_en (1 bit) and fault_sel (3 bits); both are latched at accepted start.
  - While latched fault_en=1, structural result bit fault_sel is inverted before the compare stage.
  - fault_sel>=WIDTH: no bit is inverted.
- Undefined: ports absent; structural path unmodified; behaviour identical to fault_en=0.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> busy, done, pass, err, mismatch_cnt, first_fail_valid all 0; FSM IDLE after release.
- WIDTH=2, op=0 (AND), start 1 cycle -> busy high 16 cycles, done pulse one cycle after the E18 edge, pass=1, mismatch_cnt=0, first_fail_valid=0. Repeat for ops 1..6, same result.
- WIDTH=2, op=7, start -> err one-cycle pulse, busy stays 0, no done; mismatch_cnt unchanged.
- NAND_FAULT_INJ_EN, WIDTH=2, op=0, fault_en=1, fault_sel=0 -> mismatch_cnt=16, pass=0, first_fail_a=0, first_fail_b=0. With fault_sel=5 -> pass=1.
- WIDTH=2, op=4: assert abort on the 5th RUN cycle -> busy low next cycle, done never pulses. New start with op=5 -> full sweep passes.
- WIDTH=2: start again while busy -> ignored and sweep ends on the original schedule. Drop rst_n at RUN cycle 8 -> all outputs 0 immediately; no done after release.
